// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) MSB-first SPI master with a programmable sck divider.
// Optional feature: define SPI_MASTER_LOOPBACK_EN to add a loopback input that samples mosi instead of miso.
module spi_master #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done,
    output logic             cs,
    output logic             sck,
    output logic             mosi,
    input  logic             miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic             loopback
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] LOW   = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    // The MSB goes straight to mosi at start, so only the remaining bits are kept.
    logic [WIDTH-2:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic             phase_end;
    logic             sample_bit;

    assign phase_end = (div_cnt == '0);

`ifdef SPI_MASTER_LOOPBACK_EN
    assign sample_bit = loopback ? mosi : miso;
`else
    assign sample_bit = miso;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cs       <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                div_cnt <= phase_end ? DIV_LOAD : div_cnt - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        mosi     <= tx_data[WIDTH-1];
                        tx_shift <= tx_data[WIDTH-2:0];
                        bit_cnt  <= BIT_LOAD;
                        div_cnt  <= DIV_LOAD;
                        state    <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (phase_end) begin
                        sck      <= 1'b1;
                        rx_shift <= {rx_shift[WIDTH-2:0], sample_bit};
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        sck <= 1'b0;
                        if (bit_cnt != '0) begin
                            mosi     <= tx_shift[WIDTH-2];
                            tx_shift <= tx_shift << 1;
                            bit_cnt  <= bit_cnt - 1'b1;
                            state    <= LOW;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (phase_end) begin
                        cs      <= 1'b1;
                        mosi    <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master with a behavioural mode-0 slave on miso.
// Define SPI_MASTER_LOOPBACK_EN to also exercise the loopback input.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       cs;
    logic       sck;
    logic       mosi;
    logic       miso = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Monitor state shared between the slave model and the scenario tasks.
    logic [7:0] slave_word = 8'h00;
    logic [7:0] slave_shift = 8'h00;
    logic [7:0] mosi_log = 8'h00;
    int         rise_count = 0;
    int         cs_low_cycles = 0;
    int         done_count = 0;
    int         cyc = 0;
    int         timed_out = 0;

    spi_master #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tx_data (tx_data),
        .rx_data (rx_data),
        .busy    (busy),
        .done    (done),
        .cs      (cs),
        .sck     (sck),
        .mosi    (mosi),
        .miso    (miso)
`ifdef SPI_MASTER_LOOPBACK_EN
        ,
        .loopback(loopback)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mode-0 slave: first bit valid at cs fall, next bit presented on each sck fall.
    always @(negedge cs) begin
        slave_shift = slave_word;
        miso = slave_word[7];
    end

    always @(negedge sck) begin
        if (cs === 1'b0) begin
            slave_shift = slave_shift << 1;
            miso = slave_shift[7];
        end
    end

    always @(posedge sck) begin
        mosi_log = {mosi_log[6:0], mosi};
        rise_count = rise_count + 1;
    end

    always @(negedge clk) begin
        if (cs === 1'b0) cs_low_cycles = cs_low_cycles + 1;
        if (done === 1'b1) done_count = done_count + 1;
    end

    task automatic clear_monitors();
        mosi_log = 8'h00;
        rise_count = 0;
        cs_low_cycles = 0;
        done_count = 0;
    endtask

    task automatic wait_done(input int budget);
        timed_out = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                timed_out = 0;
                break;
            end
        end
        if (timed_out != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: done never seen within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checks++; if (cs !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs: got %b want 1", cs); end
        checks++; if (sck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck: got %b want 0", sck); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi: got %b want 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx: got %h want 00", rx_data); end
    endtask

    task automatic test_single();
        @(posedge clk); #2;
        clear_monitors();
        slave_word = 8'h3C;
        tx_data = 8'hA5;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        checks++; if (busy !== 1'b1 || cs !== 1'b0) begin errors++; $display("[TB] FAIL single_start: busy=%b cs=%b want 1/0", busy, cs); end
        checks++; if (mosi !== 1'b1) begin errors++; $display("[TB] FAIL single_first_bit: got %b want 1", mosi); end
        wait_done(100);
        checks++; if (mosi_log !== 8'hA5) begin errors++; $display("[TB] FAIL single_mosi: got %h want a5", mosi_log); end
        checks++; if (rise_count != 8) begin errors++; $display("[TB] FAIL single_rises: got %0d want 8", rise_count); end
        checks++; if (cs_low_cycles != 34) begin errors++; $display("[TB] FAIL single_cs_low: got %0d want 34", cs_low_cycles); end
        checks++; if (cs !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done_cycle: cs=%b busy=%b want 1/0", cs, busy); end
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("[TB] FAIL single_rx: got %h want 3c", rx_data); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width: got %b want 0", done); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL single_mosi_idle: got %b want 0", mosi); end
    endtask

    task automatic test_start_while_busy();
        @(posedge clk); #2;
        clear_monitors();
        slave_word = 8'h96;
        tx_data = 8'hA5;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        tx_data = 8'h5A;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(100);
        checks++; if (mosi_log !== 8'hA5) begin errors++; $display("[TB] FAIL busy_mosi: got %h want a5", mosi_log); end
        checks++; if (rx_data !== 8'h96) begin errors++; $display("[TB] FAIL busy_rx: got %h want 96", rx_data); end
        repeat (40) @(negedge clk);
        checks++; if (done_count != 1) begin errors++; $display("[TB] FAIL busy_done_count: got %0d want 1", done_count); end
        checks++; if (busy !== 1'b0 || cs !== 1'b1) begin errors++; $display("[TB] FAIL busy_idle_after: busy=%b cs=%b want 0/1", busy, cs); end
    endtask

    task automatic test_back_to_back();
        int first_done;
        @(posedge clk); #2;
        clear_monitors();
        slave_word = 8'h69;
        tx_data = 8'hFF;
        start = 1'b1;
        wait_done(100);
        first_done = cyc;
        checks++; if (cs !== 1'b1) begin errors++; $display("[TB] FAIL b2b_cs_gap: got %b want 1", cs); end
        checks++; if (mosi_log !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_mosi_first: got %h want ff", mosi_log); end
        tx_data = 8'h00;
        slave_word = 8'hC6;
        @(negedge clk);
        checks++; if (cs !== 1'b0) begin errors++; $display("[TB] FAIL b2b_restart: cs=%b want 0", cs); end
        checks++; if (rx_data !== 8'h69) begin errors++; $display("[TB] FAIL b2b_rx_first: got %h want 69", rx_data); end
        start = 1'b0;
        wait_done(100);
        checks++; if (cyc - first_done != 35) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d want 35", cyc - first_done); end
        checks++; if (mosi_log !== 8'h00) begin errors++; $display("[TB] FAIL b2b_mosi_second: got %h want 00", mosi_log); end
        checks++; if (rx_data !== 8'hC6) begin errors++; $display("[TB] FAIL b2b_rx_second: got %h want c6", rx_data); end
        checks++; if (rise_count != 16) begin errors++; $display("[TB] FAIL b2b_rises: got %0d want 16", rise_count); end
    endtask

    task automatic test_reset_mid();
        int waited;
        @(posedge clk); #2;
        clear_monitors();
        slave_word = 8'hFF;
        tx_data = 8'hF0;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        waited = 0;
        while (rise_count < 4 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (rise_count != 4) begin errors++; $display("[TB] FAIL mid_rise_wait: got %0d want 4", rise_count); end
        #1 rst = 1'b1;
        #1;
        checks++; if (cs !== 1'b1 || sck !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_pins: cs=%b sck=%b want 1/0", cs, sck); end
        checks++; if (busy !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_state: busy=%b rx=%h want 0/00", busy, rx_data); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (done_count != 0) begin errors++; $display("[TB] FAIL mid_no_done: got %0d want 0", done_count); end
        @(posedge clk); #2;
        clear_monitors();
        slave_word = 8'hC3;
        tx_data = 8'h81;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(100);
        checks++; if (mosi_log !== 8'h81) begin errors++; $display("[TB] FAIL mid_mosi: got %h want 81", mosi_log); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("[TB] FAIL mid_rx: got %h want c3", rx_data); end
        checks++; if (cs_low_cycles != 34) begin errors++; $display("[TB] FAIL mid_cs_low: got %0d want 34", cs_low_cycles); end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback();
        @(posedge clk); #2;
        clear_monitors();
        slave_word = 8'h00;
        loopback = 1'b1;
        tx_data = 8'hC3;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(100);
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("[TB] FAIL loopback_rx: got %h want c3", rx_data); end
        checks++; if (rise_count != 8) begin errors++; $display("[TB] FAIL loopback_rises: got %0d want 8", rise_count); end
        loopback = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI bus master that drives the chip-select, serial-clock and MOSI lines of the team's spi_slave and captures its MISO response.
- Sits directly upstream of spi_slave; replaces the hand-driven cs/sck/mosi stimulus in slave-level benches.
- Runs one full-duplex transfer per start request: mode 0 (CPOL=0, CPHA=0), MSB first.
- sck is generated from the system clock by a programmable divider.

Parameters:
WIDTH, 8, bits per transfer (>=2).
CLK_DIV, 2, system-clock cycles per sck half-period (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  transfer request, sampled only when idle
tx_data  input  WIDTH  word to transmit, latched when start is accepted
rx_data  output  WIDTH  last received word, valid from done onward
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse when a transfer completes
cs  output  1  chip select to slave, active low
sck  output  1  serial clock to slave, idles low
mosi  output  1  master out, slave in
miso  input  1  master in, slave out

Behaviour:
- Reset (async, rst=1): state=IDLE, cs=1, sck=0, mosi=0, busy=0, done=0, rx_data=0, shift register=0, counters=0.
- States: IDLE, SETUP, HIGH, LOW, HOLD.
- Divider: one counter loads CLK_DIV-1 on each state/phase entry and counts down; a phase ends when the counter is 0. Every phase therefore lasts exactly CLK_DIV cycles.
- IDLE: start=1 at edge T0 -> at T1: cs=0, busy=1, mosi=tx_data[WIDTH-1], shift reg=tx_data, bit counter=WIDTH-1, go to SETUP.
- SETUP (CLK_DIV cycles) -> sck=1, go to HIGH.
- Rising-edge sample: on the clk edge that sets sck=1, miso is shifted into the receive register LSB (shift left).
- HIGH (CLK_DIV cycles):
  - bit counter != 0: sck=0, shift tx left, mosi=next bit, bit counter decrements, go to LOW.
  - bit counter == 0: sck=0, go to HOLD; mosi holds the last bit.
- LOW (CLK_DIV cycles) -> sck=1 with miso sample, go to HIGH.
- HOLD (CLK_DIV cycles) -> cs=1, mosi=0, busy=0, done=1 for one cycle, rx_data=receive register, go to IDLE.
- Timing: cs is low for exactly CLK_DIV*(2*WIDTH+1) cycles; done is asserted in the cycle cs returns high. Default parameters give 34 cycles.
- sck produces exactly WIDTH rising edges per transfer. mosi changes only while sck=0 (on falling edges or at cs assertion).
- start while busy=1: ignored; tx_data is not re-latched.
- start in the done cycle: accepted. cs is high for exactly 1 cycle before the next transfer.
- rx_data holds its value until the next done; it does not change mid-transfer.
- Reset mid-transfer: immediately returns to the reset values; done is not pulsed; rx_data=0.
- All outputs are registered; no combinational path from miso or start to any output.

Optional Feature:
SPI_MASTER_LOOPBACK_EN
- Defined: adds input port loopback (1 bit). While loopback=1, the sample source is the internal mosi register instead of miso, so rx_data equals tx_data after the transfer. The cs/sck/mosi pins still toggle normally.
- Undefined: no loopback port; the sample source is always miso.

Test Plan:
- Reset: rst=1 for 3 cycles, then released -> cs=1, sck=0, mosi=0, busy=0, done=0, rx_data=0.
- Single transfer: tx_data=0xA5, slave model returns 0x3C -> mosi bits 1,0,1,0,0,1,0,1 on 8 sck rising edges; cs low exactly 34 cycles; done pulses 1 cycle; rx_data=0x3C.
- Start while busy: tx_data=0x5A, start pulsed 10 cycles into a transfer of 0xA5 -> no effect; only one done; mosi sequence matches 0xA5.
- Back-to-back: start held high, words 0xFF then 0x00 -> cs high exactly 1 cycle between transfers; two done pulses 35 cycles apart.
- Reset mid-transfer: rst asserted after the 4th sck rise -> cs=1 and sck=0 immediately; no done; a new 0x81 transfer then completes correctly.
- Loopback (with SPI_MASTER_LOOPBACK_EN, loopback=1, miso held 0): tx_data=0xC3 -> rx_data=0xC3.
